// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if
//   Bundles the three handshakes around the frame loader so they travel as
//   one port.
//   sample_valid / sample_data / sample_ready : upstream valid/ready sample stream
//   it_cnt_strobe / serial_out                : shift enable and word for the
//                                               serial-to-parallel input register
//   fft_ready / frame_start / fft_done        : frame handoff with the FFT core
//   Modports:
//     slave  - loader side (fft_frame_loader)
//     master - environment side (sample front end, shift register, FFT core)
interface fft_frame_loader_if #(
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              sample_ready;
  logic              it_cnt_strobe;
  logic [DATA_W-1:0] serial_out;
  logic              fft_ready;
  logic              frame_start;
  logic              fft_done;

  modport slave (
    input  sample_valid, sample_data, fft_ready, fft_done,
    output sample_ready, it_cnt_strobe, serial_out, frame_start
  );

  modport master (
    output sample_valid, sample_data, fft_ready, fft_done,
    input  sample_ready, it_cnt_strobe, serial_out, frame_start
  );
endinterface

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//   Sequences the serial-to-parallel input shift register that feeds the FFT
//   core. Accepted samples are replayed one cycle later as a registered shift
//   strobe plus word. After NUM_SAMPLES shifts the full frame is handed to the
//   core with a one-cycle frame_start. New input is then held off until the
//   core pulses fft_done.
//   Ports:
//     clk          - system clock (400 MHz)
//     n_rst        - asynchronous active-low reset
//     enable       - level-sensitive permission to fill frames
//     abort        - synchronous frame abort, returns to IDLE
//     bus          - sample stream, shift-register feed and core handshake
//     busy         - high whenever the loader is not IDLE
//     sample_count - samples accepted into the current frame
//     frame_count  - frames handed to the core, wraps 255 -> 0
module fft_frame_loader #(
  parameter int NUM_SAMPLES = 48,
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              abort,
  fft_frame_loader_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  sample_count,
  output logic [7:0]        frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    WAIT_CORE,
    PROCESS
  } state_t;

  state_t state;
  state_t state_next;

  logic              ready;
  logic              accept;
  logic              last_sample;
  logic              handoff;
  logic              strobe_q;
  logic [DATA_W-1:0] serial_q;
  logic              frame_start_q;

  // The accept that lands on this count completes the frame.
  assign last_sample = (sample_count == CNT_W'(NUM_SAMPLES - 1));
  assign accept      = bus.sample_valid && ready;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      state <= state_next;
    end
  end

  // Next-state logic. Abort overrides every transition, including the
  // WAIT_CORE handoff when fft_ready arrives in the same cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned
    // and infers a latch.
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (enable) state_next = FILL;
        FILL:      if (accept && last_sample) state_next = FLUSH;
        FLUSH:     state_next = WAIT_CORE;
        WAIT_CORE: if (bus.fft_ready) state_next = PROCESS;
        PROCESS:   if (bus.fft_done) state_next = enable ? FILL : IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Combinational outputs. Leaving FILL on the last accept drops ready on the
  // following edge, so no sample beyond NUM_SAMPLES is taken.
  always_comb begin
    ready   = (state == FILL) && enable && !abort;
    busy    = (state != IDLE);
    handoff = (state == WAIT_CORE) && bus.fft_ready && !abort;
  end

  assign bus.sample_ready = ready;

  // Registered outputs and counters. An accepted sample is replayed as
  // strobe + word in the next cycle, so the register shifts one edge later.
  // Abort gates ready, so no strobe is ever produced for a sample presented
  // alongside abort.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strobe_q      <= 1'b0;
      serial_q      <= '0;
      frame_start_q <= 1'b0;
      sample_count  <= '0;
      frame_count   <= '0;
    end else begin
      strobe_q      <= accept;
      frame_start_q <= handoff;
      if (accept) begin
        serial_q <= bus.sample_data;
      end
      if (abort || handoff) begin
        sample_count <= '0;
      end else if (accept) begin
        sample_count <= sample_count + CNT_W'(1);
      end
      if (handoff) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign bus.it_cnt_strobe = strobe_q;
  assign bus.serial_out    = serial_q;
  assign bus.frame_start   = frame_start_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader
//   Directed bench for fft_frame_loader. A negedge monitor models the external
//   48-word shift register and counts strobes and frame_start pulses; each
//   scenario task drives stimulus and compares against hand-derived values.
module tb_fft_frame_loader;

  logic       clk;
  logic       n_rst;
  logic       enable;
  logic       abort;
  logic       busy;
  logic [5:0] sample_count;
  logic [7:0] frame_count;

  int errors = 0;
  int checks = 0;

  fft_frame_loader_if #(.DATA_W(16)) dut_if ();

  fft_frame_loader #(
    .NUM_SAMPLES(48),
    .DATA_W     (16),
    .CNT_W      (6)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .abort       (abort),
    .bus         (dut_if),
    .busy        (busy),
    .sample_count(sample_count),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: shift-register model, strobe / frame_start counters, cycle stamps.
  int          ncyc       = 0;
  int          strobe_cnt = 0;
  int          fs_cnt     = 0;
  int          acc_cyc    = 0;
  int          fs_cyc     = 0;
  logic [15:0] sreg [48];

  always @(negedge clk) begin
    ncyc++;
    if (dut_if.it_cnt_strobe === 1'b1) begin
      for (int i = 0; i < 47; i++) sreg[i] = sreg[i+1];
      sreg[47] = dut_if.serial_out;
      strobe_cnt++;
    end
    if (dut_if.frame_start === 1'b1) begin
      fs_cnt++;
      fs_cyc = ncyc;
    end
    if (dut_if.sample_valid === 1'b1 && dut_if.sample_ready === 1'b1) acc_cyc = ncyc;
  end

  function automatic int frame_bad(input int base);
    int n = 0;
    for (int i = 0; i < 48; i++) begin
      if (sreg[i] !== 16'(base + i)) n++;
    end
    return n;
  endfunction

  // ---------------- stimulus helpers (all start and end at posedge+1) -------
  task automatic send(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    dut_if.sample_valid = 1'b1;
    dut_if.sample_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut_if.sample_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    dut_if.sample_valid = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dut_if.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int base, output bit ok);
    bit s_ok;
    ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send(16'(base + i), s_ok);
      if (!s_ok) begin
        ok = 1'b0;
        return;
      end
    end
    wait_fs(s_ok);
    ok = s_ok;
  endtask

  task automatic pulse_done;
    dut_if.fft_done = 1'b1;
    @(posedge clk); #1;
    dut_if.fft_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset;
    n_rst = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (dut_if.sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", dut_if.sample_ready); end
    checks++; if (dut_if.it_cnt_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", dut_if.it_cnt_strobe); end
    checks++; if (dut_if.serial_out !== 16'd0) begin errors++; $display("FAIL reset_serial: got %0d want 0", dut_if.serial_out); end
    checks++; if (dut_if.frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %0b want 0", dut_if.frame_start); end
    checks++; if (sample_count !== 6'd0) begin errors++; $display("FAIL reset_sample_count: got %0d want 0", sample_count); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_enable_busy: got %0b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int s0, f0;
    bit ok;
    s0 = strobe_cnt;
    f0 = fs_cnt;
    dut_if.fft_ready = 1'b1;
    enable = 1'b1;
    run_frame(1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_timeout: got %0b want 1", ok); end
    checks++; if (strobe_cnt - s0 !== 48) begin errors++; $display("FAIL fill_strobes: got %0d want 48", strobe_cnt - s0); end
    checks++; if (sreg[0] !== 16'd1) begin errors++; $display("FAIL fill_word0: got %0d want 1", sreg[0]); end
    checks++; if (sreg[47] !== 16'd48) begin errors++; $display("FAIL fill_word47: got %0d want 48", sreg[47]); end
    checks++; if (frame_bad(1) !== 0) begin errors++; $display("FAIL fill_order: got %0d bad words want 0", frame_bad(1)); end
    checks++; if (fs_cyc - acc_cyc !== 3) begin errors++; $display("FAIL fill_latency: got %0d cycles want 3", fs_cyc - acc_cyc); end
    checks++; if (fs_cnt - f0 !== 1) begin errors++; $display("FAIL fill_frame_starts: got %0d want 1", fs_cnt - f0); end
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL fill_frame_count: got %0d want 1", frame_count); end
    checks++; if (sample_count !== 6'd0) begin errors++; $display("FAIL fill_sample_count: got %0d want 0", sample_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy_process: got %0b want 1", busy); end
  endtask

  task automatic test_done_restart;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL process_hold_busy: got %0b want 1", busy); end
    pulse_done();
    @(negedge clk);
    checks++; if (dut_if.sample_ready !== 1'b1) begin errors++; $display("FAIL restart_fill_ready: got %0b want 1", dut_if.sample_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %0b want 1", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps;
    int  s0, sp, bad;
    bit  ok, all_ok;
    s0 = strobe_cnt;
    all_ok = 1'b1;
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      send(16'(101 + i), ok);
      if (!ok) all_ok = 1'b0;
      @(posedge clk); #1;
      if (i == 19) begin
        enable = 1'b0;
        dut_if.sample_valid = 1'b1;
        dut_if.sample_data  = 16'd121;
        sp = strobe_cnt;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (dut_if.sample_ready !== 1'b0 || sample_count !== 6'd20) bad++;
        end
        @(posedge clk); #1;
        checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles want 0", bad); end
        checks++; if (strobe_cnt - sp !== 0) begin errors++; $display("FAIL pause_strobes: got %0d want 0", strobe_cnt - sp); end
        dut_if.sample_valid = 1'b0;
        enable = 1'b1;
      end
    end
    wait_fs(ok);
    checks++; if ((all_ok && ok) !== 1'b1) begin errors++; $display("FAIL gaps_timeout: got %0b want 1", all_ok && ok); end
    checks++; if (strobe_cnt - s0 !== 48) begin errors++; $display("FAIL gaps_strobes: got %0d want 48", strobe_cnt - s0); end
    checks++; if (frame_bad(101) !== 0) begin errors++; $display("FAIL gaps_order: got %0d bad words want 0", frame_bad(101)); end
    checks++; if (frame_count !== 8'd2) begin errors++; $display("FAIL gaps_frame_count: got %0d want 2", frame_count); end
  endtask

  task automatic test_core_stall;
    int s0, bad;
    bit ok, all_ok;
    dut_if.fft_ready = 1'b0;
    pulse_done();
    s0 = strobe_cnt;
    all_ok = 1'b1;
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      send(16'(201 + i), ok);
      if (!ok) all_ok = 1'b0;
    end
    dut_if.sample_valid = 1'b1;
    dut_if.sample_data  = 16'd999;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dut_if.sample_ready !== 1'b0 || dut_if.frame_start !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    @(posedge clk); #1;
    dut_if.fft_ready    = 1'b1;
    dut_if.sample_valid = 1'b0;
    @(negedge clk);
    checks++; if (dut_if.frame_start !== 1'b0) begin errors++; $display("FAIL stall_fs_early: got %0b want 0", dut_if.frame_start); end
    @(negedge clk);
    checks++; if (dut_if.frame_start !== 1'b1) begin errors++; $display("FAIL stall_fs_pulse: got %0b want 1", dut_if.frame_start); end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL stall_frame_count: got %0d want 3", frame_count); end
    @(negedge clk);
    checks++; if (dut_if.frame_start !== 1'b0) begin errors++; $display("FAIL stall_fs_width: got %0b want 0", dut_if.frame_start); end
    @(posedge clk); #1;
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL stall_timeout: got %0b want 1", all_ok); end
    checks++; if (strobe_cnt - s0 !== 48) begin errors++; $display("FAIL stall_strobes: got %0d want 48", strobe_cnt - s0); end
    checks++; if (frame_bad(201) !== 0) begin errors++; $display("FAIL stall_order: got %0d bad words want 0", frame_bad(201)); end
  endtask

  task automatic test_done_idle;
    enable = 1'b0;
    pulse_done();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_idle_busy: got %0b want 0", busy); end
    checks++; if (dut_if.sample_ready !== 1'b0) begin errors++; $display("FAIL done_idle_ready: got %0b want 0", dut_if.sample_ready); end
    @(posedge clk); #1;
    pulse_done();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_done_busy: got %0b want 0", busy); end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL stray_done_frame_count: got %0d want 3", frame_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int s0, f0;
    bit ok, all_ok;
    // Abort while the 30th sample is presented.
    s0 = strobe_cnt;
    f0 = fs_cnt;
    all_ok = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 29; i++) begin
      send(16'(301 + i), ok);
      if (!ok) all_ok = 1'b0;
    end
    dut_if.sample_valid = 1'b1;
    dut_if.sample_data  = 16'd330;
    abort = 1'b1;
    @(negedge clk);
    checks++; if (dut_if.sample_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b want 0", dut_if.sample_ready); end
    @(posedge clk); #1;
    abort = 1'b0;
    dut_if.sample_valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
    checks++; if (sample_count !== 6'd0) begin errors++; $display("FAIL abort_sample_count: got %0d want 0", sample_count); end
    checks++; if (dut_if.it_cnt_strobe !== 1'b0) begin errors++; $display("FAIL abort_strobe: got %0b want 0", dut_if.it_cnt_strobe); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL abort_fill_timeout: got %0b want 1", all_ok); end
    checks++; if (strobe_cnt - s0 !== 29) begin errors++; $display("FAIL abort_strobes: got %0d want 29", strobe_cnt - s0); end
    checks++; if (fs_cnt - f0 !== 0) begin errors++; $display("FAIL abort_frame_start: got %0d want 0", fs_cnt - f0); end
    checks++; if (frame_count !== 8'd3) begin errors++; $display("FAIL abort_frame_count: got %0d want 3", frame_count); end

    // A fresh frame after the abort loads cleanly.
    enable = 1'b1;
    dut_if.fft_ready = 1'b1;
    s0 = strobe_cnt;
    run_frame(401, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL refill_timeout: got %0b want 1", ok); end
    checks++; if (strobe_cnt - s0 !== 48) begin errors++; $display("FAIL refill_strobes: got %0d want 48", strobe_cnt - s0); end
    checks++; if (frame_bad(401) !== 0) begin errors++; $display("FAIL refill_order: got %0d bad words want 0", frame_bad(401)); end
    checks++; if (frame_count !== 8'd4) begin errors++; $display("FAIL refill_frame_count: got %0d want 4", frame_count); end

    // Abort in PROCESS; the following fft_done must not move the loader.
    enable = 1'b0;
    dut_if.fft_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_process_busy: got %0b want 0", busy); end
    @(posedge clk); #1;
    pulse_done();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_process_done_busy: got %0b want 0", busy); end

    // Abort together with fft_ready in WAIT_CORE: abort wins.
    @(posedge clk); #1;
    enable = 1'b1;
    all_ok = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send(16'(501 + i), ok);
      if (!ok) all_ok = 1'b0;
    end
    @(posedge clk); #1;
    f0 = fs_cnt;
    abort = 1'b1;
    dut_if.fft_ready = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    dut_if.fft_ready = 1'b0;
    @(negedge clk);
    checks++; if (dut_if.frame_start !== 1'b0) begin errors++; $display("FAIL abort_wait_fs: got %0b want 0", dut_if.frame_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_wait_busy: got %0b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL abort_wait_fill_timeout: got %0b want 1", all_ok); end
    checks++; if (fs_cnt - f0 !== 0) begin errors++; $display("FAIL abort_wait_fs_count: got %0d want 0", fs_cnt - f0); end
    checks++; if (frame_count !== 8'd4) begin errors++; $display("FAIL abort_wait_frame_count: got %0d want 4", frame_count); end
  endtask

  task automatic test_reset_mid;
    bit ok, all_ok;
    all_ok = 1'b1;
    enable = 1'b1;
    dut_if.fft_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(16'(601 + i), ok);
      if (!ok) all_ok = 1'b0;
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if ({busy, dut_if.sample_ready, dut_if.it_cnt_strobe, dut_if.frame_start} !== 4'b0) begin
      errors++; $display("FAIL rst_fill_flags: got %b want 0000", {busy, dut_if.sample_ready, dut_if.it_cnt_strobe, dut_if.frame_start}); end
    checks++; if (dut_if.serial_out !== 16'd0) begin errors++; $display("FAIL rst_fill_serial: got %0d want 0", dut_if.serial_out); end
    checks++; if (sample_count !== 6'd0) begin errors++; $display("FAIL rst_fill_sample_count: got %0d want 0", sample_count); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL rst_fill_frame_count: got %0d want 0", frame_count); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send(16'(701 + i), ok);
      if (!ok) all_ok = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_core_busy: got %0b want 1", busy); end
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if ({busy, dut_if.sample_ready, dut_if.it_cnt_strobe, dut_if.frame_start} !== 4'b0) begin
      errors++; $display("FAIL rst_wait_flags: got %b want 0000", {busy, dut_if.sample_ready, dut_if.it_cnt_strobe, dut_if.frame_start}); end
    checks++; if (dut_if.serial_out !== 16'd0) begin errors++; $display("FAIL rst_wait_serial: got %0d want 0", dut_if.serial_out); end
    checks++; if (sample_count !== 6'd0) begin errors++; $display("FAIL rst_wait_sample_count: got %0d want 0", sample_count); end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL rst_fill_timeout: got %0b want 1", all_ok); end
    enable = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame_wrap;
    int fails;
    bit ok;
    fails = 0;
    enable = 1'b1;
    dut_if.fft_ready = 1'b1;
    for (int f = 1; f <= 256; f++) begin
      run_frame(f, ok);
      if (!ok) begin
        fails++;
        break;
      end
      if (f == 255) begin
        checks++; if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", frame_count); end
      end
      pulse_done();
    end
    checks++; if (fails !== 0) begin errors++; $display("FAIL wrap_timeout: got %0d want 0", fails); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d want 0", frame_count); end
  endtask

  initial begin
    n_rst  = 1'b1;
    enable = 1'b0;
    abort  = 1'b0;
    dut_if.sample_valid = 1'b0;
    dut_if.sample_data  = 16'd0;
    dut_if.fft_ready    = 1'b0;
    dut_if.fft_done     = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_done_restart();
    test_gaps();
    test_core_stall();
    test_done_idle();
    test_abort();
    test_reset_mid();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
